mxint8_block_dequant: RTL and testbench
=======================================

// Module: mxint8_block_dequant
// PURPOSE
//  Consumes one MXINT8 block (shared 8-bit scale + BLOCK_SIZE int8 elements), as produced by
//  mxint8_broadcast and the MX ALU lanes, and streams it back out as float32 values.
//  Output rate is one float32 per cycle over a valid/ready handshake, in element index order.
//  Sits on the MX ALU result path, ahead of scalar float32 consumers.
//  Conversion is exact: no rounding is ever required.
// PARAMETERS
//  BLOCK_SIZE  `BLOCK_SIZE (32)      elements per block
//  IDX_W       $clog2(BLOCK_SIZE)    width of o_index
// PORTS
//  i_clk               in   1                       clock; all state on rising edge
//  i_rst_n             in   1                       asynchronous active-low reset
//  i_valid             in   1                       input block valid
//  o_ready             out  1                       block accepted when i_valid & o_ready
//  i_scale             in   `SCALE_WIDTH            shared E8M0 scale (bias 127, 0xFF = NaN)
//  i_mxint8_elements   in   `MXINT8_ELEMENT_WIDTH   [BLOCK_SIZE-1:0] elements: 2's compl, 1.6 fixed point
//  o_valid             out  1                       float32 output valid
//  i_ready             in   1                       downstream ready
//  o_float32           out  `FLOAT32_WIDTH          converted element
//  o_index             out  IDX_W                   element index of o_float32
//  o_last              out  1                       o_index == BLOCK_SIZE-1
// BEHAVIOUR
//  Reset: FSM=IDLE, o_valid=0, o_index=0, o_last=0, o_float32=0; captured scale/elements cleared.
//  FSM IDLE
//    o_ready=1.
//    On accept: capture scale and all elements, index<=0, go STREAM.
//    First o_valid appears the cycle after accept.
//  FSM STREAM
//    o_valid=1.
//    On o_valid & i_ready: index++.
//    Last-element handshake with no new accept: go IDLE.
//    o_ready = o_last & i_ready, i.e. zero-bubble back-to-back blocks.
//    Simultaneous last handshake + accept: capture the new block, index<=0, stay STREAM.
//  Stall
//    o_float32, o_index and o_last are held stable while o_valid & ~i_ready.
//    Input bus is ignored unless accepted.
//  o_float32 is a combinational function of the registered scale and element[index].
//    It is 0 whenever o_valid=0.
//  Conversion (s = scale, e = element, mag = |e| in 8 bits, p = position of MSB of mag):
//    s==0xFF: 0x7FC00000 (qNaN) for every element, regardless of e.
//    e==0: 0x00000000 (+0).
//    Otherwise:
//      sign = e[7].
//      biased exponent E = s + p - 6 (signed, 10-bit arithmetic).
//      mantissa = bits of mag below p, left-aligned into 23 bits, zero-filled.
//    e==-128: mag=128, p=7 (-2.0 * 2^(s-127)).
//    E>=255 (only s=254, e=-128): saturate to 0xFF7FFFFF; no infinity is produced.
//    E<=0: see CONFIGURATION.
//  Reset mid-block: the block is dropped and no further outputs are driven; no flush.
// CONFIGURATION
//  MXINT8_DEQUANT_SUBNORMAL_EN
//    Defined: E<=0 yields a float32 subnormal, exponent 0, mantissa = mag << (s+16).
//      Exact, since s<=6 in this case.
//    Undefined: E<=0 is flushed to signed zero {sign, 31'b0}.
// STRUCTURE
//  Shared include files (scalar_includes.v / mxint8_includes.v):
//    FLOAT32_* widths/fields, SCALE_WIDTH, MXINT8_ELEMENT_WIDTH, BLOCK_SIZE.
//    New constants: FLOAT32_QNAN, FLOAT32_NEG_MAX, MXINT8_FRAC_BITS (=6).
//  Sub-module mxint8_element_to_float32: combinational {scale, element} -> float32.
//    Contains the priority encoder and the macro-dependent subnormal path.
//    Reused by the future vector dequant path.
//  Top: FSM, block capture registers, index counter, handshake.
// TESTING
//  1. s=127, all e=64; i_ready=1 -> 32 beats of 0x3F800000, o_index 0..31, o_last on beat 31 only.
//  2. s=127, e[0]=-128, e[1]=1, e[2]=0, e[3]=-1 -> 0xC0000000, 0x3C800000, 0x00000000, 0xBC800000.
//  3. s=0xFF with arbitrary e -> all beats 0x7FC00000.
//     s=254, e=-128 -> 0xFF7FFFFF.
//  4. s=0, e=64:
//       without EN -> 0x00000000; e=-64 -> 0x80000000.
//       with EN    -> 0x00400000; e=1 -> 0x00010000.
//  5. Drop i_ready for 3 cycles at index 5 -> outputs frozen at index 5, no element skipped or repeated.
//     Back-to-back blocks with i_valid held -> no idle cycle between o_last and the next block's index 0.
//  6. Assert i_rst_n=0 at index 10 -> o_valid=0 immediately.
//     After release, o_ready=1 and the next block starts at index 0.

Source files
------------

// File: rtl/mxint8_block_dequant_pkg.sv
// Shared constants and types for the MXINT8 block dequantiser.
// Optional subnormal output is enabled by defining MXINT8_DEQUANT_SUBNORMAL_EN.
package mxint8_block_dequant_pkg;

  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int MXINT8_FRAC_BITS     = 6;
  localparam int FLOAT32_WIDTH        = 32;
  localparam int FLOAT32_EXP_WIDTH    = 8;
  localparam int FLOAT32_MANT_WIDTH   = 23;

  localparam logic [SCALE_WIDTH-1:0]   SCALE_NAN       = 8'hFF;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_QNAN    = 32'h7FC0_0000;
  localparam logic [FLOAT32_WIDTH-1:0] FLOAT32_NEG_MAX = 32'hFF7F_FFFF;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/mxint8_element_to_float32.sv
// Combinational {E8M0 scale, int8 1.6 element} -> exact float32.
// E<=0 results become subnormals when MXINT8_DEQUANT_SUBNORMAL_EN is defined, else signed zero.
module mxint8_element_to_float32
  import mxint8_block_dequant_pkg::*;
(
  input  logic [SCALE_WIDTH-1:0]          scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] element,
  output logic [FLOAT32_WIDTH-1:0]        float32
);

  logic              sign;
  logic [7:0]        mag;
  logic [2:0]        msb;
  logic signed [9:0] exp_b;
  logic [6:0]        frac;
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
  logic [FLOAT32_MANT_WIDTH-1:0] sub_mant;
`endif

  always_comb begin
    sign = element[7];
    // -128 negates to 8'h80, which is the correct unsigned magnitude
    mag  = sign ? (8'd0 - element) : element;
    msb  = '0;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) msb = 3'(i);
    end
    exp_b = $signed({2'b00, scale}) + $signed({7'b0, msb}) - 10'(MXINT8_FRAC_BITS);
    frac  = 7'(mag << (3'd7 - msb));
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
    // Only used when exp_b <= 0, which bounds scale to 6 and keeps the shift exact
    sub_mant = {15'd0, mag} << (6'(scale) + 6'd16);
`endif

    float32 = '0;
    if (scale == SCALE_NAN) begin
      float32 = FLOAT32_QNAN;
    end else if (mag == 8'd0) begin
      float32 = '0;
    end else if (exp_b >= 10'sd255) begin
      float32 = {sign, FLOAT32_NEG_MAX[30:0]};
    end else if (exp_b <= 10'sd0) begin
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
      float32 = {sign, 8'd0, sub_mant};
`else
      float32 = {sign, 31'd0};
`endif
    end else begin
      float32 = {sign, exp_b[7:0], frac, 16'd0};
    end
  end

endmodule

// File: rtl/mxint8_block_dequant.sv
// Captures one MXINT8 block and streams it out as float32, one element per beat.
// Subnormal handling follows MXINT8_DEQUANT_SUBNORMAL_EN (see mxint8_element_to_float32).
module mxint8_block_dequant
  import mxint8_block_dequant_pkg::*;
#(
  parameter int BLOCK_SIZE = 32,
  parameter int IDX_W      = $clog2(BLOCK_SIZE)
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  input  logic [SCALE_WIDTH-1:0]                     i_scale,
  input  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [FLOAT32_WIDTH-1:0]                   o_float32,
  output logic [IDX_W-1:0]                           o_index,
  output logic                                       o_last,
  output state_t                                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and payload is held stable while valid & ~ready.

  state_t                                     state_q, state_d;
  logic [SCALE_WIDTH-1:0]                     scale_q;
  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] elems_q;
  logic [IDX_W-1:0]                           index_q, index_d;
  logic                                       capture, accept, beat;
  logic [MXINT8_ELEMENT_WIDTH-1:0]            elem_sel;
  logic [FLOAT32_WIDTH-1:0]                   conv;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    capture = 1'b0;
    o_valid = (state_q == STREAM);
    o_last  = o_valid && (index_q == IDX_W'(BLOCK_SIZE - 1));
    // Accepting on the last beat lets the next block follow with no bubble
    o_ready = (state_q == IDLE) || (o_last && i_ready);
    accept  = i_valid && o_ready;
    beat    = o_valid && i_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          capture = 1'b1;
          index_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          capture = 1'b1;
          index_d = '0;
        end else if (beat) begin
          if (o_last) begin
            index_d = '0;
            state_d = IDLE;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      scale_q <= '0;
      elems_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (capture) begin
        scale_q <= i_scale;
        elems_q <= i_mxint8_elements;
      end
    end
  end

  assign elem_sel = elems_q[{index_q, 3'b000} +: MXINT8_ELEMENT_WIDTH];

  mxint8_element_to_float32 u_conv (
    .scale   (scale_q),
    .element (elem_sel),
    .float32 (conv)
  );

  assign o_float32 = o_valid ? conv : '0;
  assign o_index   = index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mxint8_block_dequant.sv
// Directed bench for mxint8_block_dequant; expectations follow MXINT8_DEQUANT_SUBNORMAL_EN.
module tb_mxint8_block_dequant;
  import mxint8_block_dequant_pkg::*;

  localparam int BS = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [7:0]   i_scale = '0;
  logic [255:0] i_elems = '0;
  logic         o_ready, o_valid, o_last;
  logic [31:0]  o_float32;
  logic [4:0]   o_index;
  state_t       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mxint8_block_dequant #(.BLOCK_SIZE(BS)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_scale           (i_scale),
    .i_mxint8_elements (i_elems),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_float32         (o_float32),
    .o_index           (o_index),
    .o_last            (o_last),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exact double -> float32 bit conversion for values in the normal float32 range
  function automatic logic [31:0] f32_of(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  task automatic push_n(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // driver: present a block and hold it until accepted
  task automatic load(input logic [7:0] s, input logic [255:0] e);
    int guard = 0;
    @(negedge clk);
    i_valid = 1'b1; i_scale = s; i_elems = e;
    #1;
    while (!o_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    chk("load_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_scale = 8'($urandom_range(0, 255));
    i_elems = {8{$urandom}};
  endtask

  // consume n beats against exp_q, optionally stalling and offering the next block
  task automatic stream(input int n, input int stall_idx, input int stall_len,
                        input bit has_nxt, input logic [7:0] ns, input logic [255:0] ne);
    int beat = 0, guard = 0, stalled = 0;
    bit first = 1'b1;
    logic [31:0] e;
    while (beat < n && guard < 200) begin
      @(negedge clk);
      if (has_nxt) begin
        i_valid = 1'b1; i_scale = ns; i_elems = ne;
      end
      i_ready = !(beat == stall_idx && stalled < stall_len);
      #1;
      if (first) begin
        chk("no_gap_valid", 32'(o_valid), 32'd1);
        first = 1'b0;
      end
      if (o_valid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        chk("data", o_float32, e);
        chk("index", 32'(o_index), 32'(beat));
        chk("last", 32'(o_last), 32'(beat == BS - 1));
        if (i_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (has_nxt && beat == BS - 1) chk("b2b_ready", 32'(o_ready), 32'd1);
          beat++;
        end else begin
          stalled++;
        end
      end
      guard++;
    end
    chk("stream_beats", 32'(beat), 32'(n));
    if (has_nxt) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
    i_ready = 1'b1;
  endtask

  initial begin
    logic [255:0] e;
    logic [255:0] eb;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_index", 32'(o_index), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_float", o_float32, 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // 1: unity values, full block
    e = {32{8'd64}};
    push_n(32'h3F80_0000, 32);
    load(8'd127, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);
    @(negedge clk); #1;
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_float", o_float32, 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

    // 2: extremes around zero at unity scale
    e = '0;
    e[7:0] = 8'h80; e[15:8] = 8'h01; e[23:16] = 8'h00; e[31:24] = 8'hFF;
    exp_q.push_back(32'hC000_0000);
    exp_q.push_back(32'h3C80_0000);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hBC80_0000);
    push_n(32'h0, 28);
    load(8'd127, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // 3a: NaN scale overrides every element
    e = {8{$urandom}};
    e[7:0] = 8'h00;
    push_n(FLOAT32_QNAN, 32);
    load(8'hFF, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // 3b: top of the exponent range, including saturation
    e = '0;
    e[7:0] = 8'h80; e[15:8] = 8'd64; e[23:16] = 8'h7F;
    exp_q.push_back(32'hFF7F_FFFF);
    exp_q.push_back(32'h7F00_0000);
    exp_q.push_back(32'h7F7E_0000);
    push_n(32'h0, 29);
    load(8'd254, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // 4: bottom of the exponent range
    e = '0;
    e[7:0] = 8'd64; e[15:8] = 8'hC0; e[23:16] = 8'd1; e[31:24] = 8'h7F; e[39:32] = 8'h80;
`ifdef MXINT8_DEQUANT_SUBNORMAL_EN
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h8040_0000);
    exp_q.push_back(32'h0001_0000);
    exp_q.push_back(32'h007F_0000);
`else
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
`endif
    exp_q.push_back(32'h8080_0000);
    push_n(32'h0, 27);
    load(8'd0, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // 5: stall at index 5, then back-to-back block with no bubble
    for (int i = 0; i < BS; i++) begin
      e[i*8 +: 8]  = 8'(i - 16);
      eb[i*8 +: 8] = 8'(4 * i - 64);
    end
    for (int i = 0; i < BS; i++) exp_q.push_back(f32_of(real'(i - 16) / 64.0));
    load(8'd127, e);
    stream(32, 5, 3, 1'b1, 8'd130, eb);
    for (int i = 0; i < BS; i++) exp_q.push_back(f32_of(real'(4 * i - 64) / 8.0));
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // 6: reset mid-block, then a fresh block from index 0
    for (int i = 0; i < BS; i++) e[i*8 +: 8] = 8'(2 * i);
    for (int i = 0; i < BS; i++) exp_q.push_back(f32_of(real'(2 * i) / 64.0));
    load(8'd127, e);
    stream(10, -1, 0, 1'b0, 8'd0, '0);
    @(negedge clk); #1;
    chk("pre_rst_index", 32'(o_index), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_index", 32'(o_index), 32'd0);
    chk("mid_rst_float", o_float32, 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BS; i++) e[i*8 +: 8] = 8'(100 - 3 * i);
    for (int i = 0; i < BS; i++) exp_q.push_back(f32_of(real'(100 - 3 * i) / 8192.0));
    load(8'd120, e);
    stream(32, -1, 0, 1'b0, 8'd0, '0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
